// File: rtl/lfsr_period_checker.sv
// Measures the repetition period of an upstream 8-bit LFSR. It also compacts every
// sampled state into an 8-bit MISR signature and flags lockup or a missing wrap.
module lfsr_period_checker (
    input  logic       Clk,
    input  logic       RS,
    input  logic       Start,
    input  logic [7:0] Q,
    output logic       Busy,
    output logic       Done,
    output logic [8:0] Period,
    output logic       Stuck,
    output logic       Timeout,
    output logic [7:0] Sig
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE, FAULT} state_t;

    localparam logic [8:0] CNT_LIMIT = 9'd511;

    state_t     state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic [8:0] period_q, period_d;
    logic [7:0] ref_q, ref_d;
    logic [7:0] prev_q, prev_d;
    logic [7:0] sig_q, sig_d;
    logic       done_q, done_d;
    logic       stuck_q, stuck_d;
    logic       timeout_q, timeout_d;
    logic [8:0] n;

    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] d);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ d;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        ref_d     = ref_q;
        prev_d    = prev_q;
        sig_d     = sig_q;
        done_d    = done_q;
        stuck_d   = stuck_q;
        timeout_d = timeout_q;
        n         = cnt_q + 9'd1;

        case (state_q)
            COUNT: begin
                sig_d = misr_step(sig_q, Q);
                // Lockup takes priority, then a wrap to the reference, then the cycle limit.
                if (Q == prev_q) begin
                    stuck_d = 1'b1;
                    state_d = FAULT;
                end else if (Q == ref_q) begin
                    period_d = n;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else if (n == CNT_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = FAULT;
                end else begin
                    cnt_d  = n;
                    prev_d = Q;
                end
            end
            default: begin
                if (Start) begin
                    ref_d     = Q;
                    prev_d    = Q;
                    cnt_d     = 9'd0;
                    sig_d     = 8'h00;
                    done_d    = 1'b0;
                    stuck_d   = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = COUNT;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge RS) begin
        if (!RS) begin
            state_q   <= IDLE;
            cnt_q     <= 9'd0;
            period_q  <= 9'd0;
            ref_q     <= 8'h00;
            prev_q    <= 8'h00;
            sig_q     <= 8'h00;
            done_q    <= 1'b0;
            stuck_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            ref_q     <= ref_d;
            prev_q    <= prev_d;
            sig_q     <= sig_d;
            done_q    <= done_d;
            stuck_q   <= stuck_d;
            timeout_q <= timeout_d;
        end
    end

    assign Busy    = (state_q == COUNT);
    assign Done    = done_q;
    assign Stuck   = stuck_q;
    assign Timeout = timeout_q;
    assign Period  = period_q;
    assign Sig     = sig_q;

endmodule

// File: tb/tb_lfsr_period_checker.sv
// Scoreboard bench for lfsr_period_checker: each measurement pushes its expected
// outcome when started and pops it for comparison once Busy drops.
module tb_lfsr_period_checker;

    logic       Clk = 1'b0;
    logic       RS = 1'b1;
    logic       Start = 1'b0;
    logic [7:0] Q = 8'h00;
    logic       Busy, Done, Stuck, Timeout;
    logic [8:0] Period;
    logic [7:0] Sig;

    int checks = 0;
    int errors = 0;
    logic [8:0] last_period = 9'd0;

    typedef struct {
        logic       done;
        logic       stuck;
        logic       timeout;
        logic [8:0] period;
        logic [7:0] sig;
        int         busy;
    } exp_t;

    exp_t sb[$];

    lfsr_period_checker dut (
        .Clk(Clk), .RS(RS), .Start(Start), .Q(Q),
        .Busy(Busy), .Done(Done), .Period(Period),
        .Stuck(Stuck), .Timeout(Timeout), .Sig(Sig)
    );

    always #5 Clk = ~Clk;

    localparam int M_SHORT = 0, M_LFSR = 1, M_CNT = 2, M_HOLD = 3, M_ALT = 4;

    function automatic logic [7:0] next_q(input int mode, input logic [7:0] q);
        case (mode)
            M_SHORT: return (q == 8'h14) ? 8'h10 : q + 8'd1;
            M_LFSR:  return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
            M_CNT:   return q + 8'd1;
            M_HOLD:  return q;
            default: return (q == 8'hAA) ? 8'h55 : 8'hAA;
        endcase
    endfunction

    function automatic logic [7:0] misr_model(input logic [7:0] s, input logic [7:0] d);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return (s << 1 | {7'd0, fb}) ^ d;
    endfunction

    always @(negedge Clk) begin
        if (RS) begin
            checks++;
            if ($countones({Done, Stuck, Timeout}) > 1) begin
                errors++;
                $display("FAIL flags_exclusive: Done=%b Stuck=%b Timeout=%b, at most one required",
                         Done, Stuck, Timeout);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic run_meas(input string name, input int mode, input logic [7:0] init,
                            input int n_edges, input logic e_done, input logic e_stuck,
                            input logic e_to, input logic [8:0] e_period);
        exp_t e;
        logic [7:0] q, s;
        int busy_n, cyc;
        q = init;
        s = 8'h00;
        for (int i = 0; i < n_edges; i++) begin
            q = next_q(mode, q);
            s = misr_model(s, q);
        end
        e.done = e_done; e.stuck = e_stuck; e.timeout = e_to;
        e.period = e_period; e.sig = s; e.busy = n_edges;
        sb.push_back(e);

        Q = init;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        Q = next_q(mode, init);
        checks++;
        if (Done !== 1'b0 || Stuck !== 1'b0 || Timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s capture_clear: Done=%b Stuck=%b Timeout=%b, all 0 required",
                     name, Done, Stuck, Timeout);
        end
        busy_n = 0;
        cyc = 0;
        while (Busy === 1'b1 && cyc < 600) begin
            busy_n++;
            @(posedge Clk); #1;
            Start = 1'b0;
            Q = next_q(mode, Q);
            cyc++;
            if (cyc == 2 && Busy === 1'b1) Start = 1'b1;
        end
        Start = 1'b0;

        e = sb.pop_front();
        checks++;
        if (cyc >= 600) begin
            errors++;
            $display("FAIL %s busy_bound: Busy still high after %0d cycles", name, cyc);
        end
        checks++;
        if (busy_n !== e.busy) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d, expected %0d", name, busy_n, e.busy);
        end
        checks++;
        if (Done !== e.done || Stuck !== e.stuck || Timeout !== e.timeout) begin
            errors++;
            $display("FAIL %s flags: got D=%b S=%b T=%b, expected D=%b S=%b T=%b",
                     name, Done, Stuck, Timeout, e.done, e.stuck, e.timeout);
        end
        checks++;
        if (Period !== e.period) begin
            errors++;
            $display("FAIL %s period: got %0d, expected %0d", name, Period, e.period);
        end
        checks++;
        if (Sig !== e.sig) begin
            errors++;
            $display("FAIL %s sig: got %h, expected %h", name, Sig, e.sig);
        end

        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            Q = next_q(mode, Q);
            checks++;
            if (Busy !== 1'b0 || Sig !== e.sig || Period !== e.period || Done !== e.done ||
                Stuck !== e.stuck || Timeout !== e.timeout) begin
                errors++;
                $display("FAIL %s frozen: Busy=%b Sig=%h Period=%0d D=%b S=%b T=%b, expected 0 %h %0d %b %b %b",
                         name, Busy, Sig, Period, Done, Stuck, Timeout,
                         e.sig, e.period, e.done, e.stuck, e.timeout);
            end
        end
        if (e_done) last_period = e_period;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Stuck !== 1'b0 || Timeout !== 1'b0 ||
            Period !== 9'd0 || Sig !== 8'h00) begin
            errors++;
            $display("FAIL %s: Busy=%b Done=%b Stuck=%b Timeout=%b Period=%0d Sig=%h, all 0 required",
                     name, Busy, Done, Stuck, Timeout, Period, Sig);
        end
    endtask

    task automatic test_reset_initial();
        #1 RS = 1'b0;
        #1 check_all_zero("reset_async_initial");
        repeat (2) @(posedge Clk);
        @(negedge Clk) RS = 1'b1;
        @(posedge Clk); #1;
        check_all_zero("reset_idle_initial");
        last_period = 9'd0;
    endtask

    task automatic test_short_cycle();
        run_meas("short", M_SHORT, 8'h10, 5, 1'b1, 1'b0, 1'b0, 9'd5);
    endtask

    task automatic test_max_lfsr();
        run_meas("lfsr", M_LFSR, 8'h01, 255, 1'b1, 1'b0, 1'b0, 9'd255);
    endtask

    task automatic test_full_counter();
        run_meas("counter", M_CNT, 8'h00, 256, 1'b1, 1'b0, 1'b0, 9'd256);
    endtask

    task automatic test_lockup();
        run_meas("lockup", M_HOLD, 8'hFF, 1, 1'b0, 1'b1, 1'b0, last_period);
    endtask

    task automatic test_timeout();
        run_meas("timeout", M_ALT, 8'h00, 511, 1'b0, 1'b0, 1'b1, last_period);
        run_meas("after_timeout", M_SHORT, 8'h12, 5, 1'b1, 1'b0, 1'b0, 9'd5);
    endtask

    task automatic test_reset_mid_count();
        Q = 8'h00;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            Q = Q + 8'd1;
            @(posedge Clk); #1;
        end
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_busy: Busy=%b, expected 1", Busy);
        end
        #2 RS = 1'b0;
        #1 check_all_zero("reset_async_mid_count");
        @(negedge Clk) RS = 1'b1;
        for (int i = 0; i < 10; i++) begin
            Q = Q + 8'd3;
            @(posedge Clk); #1;
            check_all_zero("reset_release_idle");
        end
    endtask

    initial begin
        test_reset_initial();
        test_short_cycle();
        test_max_lfsr();
        test_full_counter();
        test_lockup();
        test_timeout();
        test_reset_mid_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
